// File: rtl/fu_operand_join_merge_pkg.sv
// Shared CGRA definitions for the FU operand input stage: mode encoding,
// buffer depth and the merge arbitration helper.
package fu_operand_join_merge_pkg;

    typedef enum logic [1:0] {
        FU_IN_JOIN  = 2'd0,
        FU_IN_MERGE = 2'd1,
        FU_IN_PASS1 = 2'd2,
        FU_IN_PASS2 = 2'd3
    } fu_in_mode_t;

    localparam int FU_IN_BUF_DEPTH = 2;

    // Channel select encoding; doubles as the cin branch-select value.
    localparam logic SEL_DIN1 = 1'b0;
    localparam logic SEL_DIN2 = 1'b1;

    // Round-robin pick between two heads; rr_last names the previous winner.
    function automatic logic rr_pick(input logic h1, input logic h2, input logic rr_last);
        logic pick;
        pick = SEL_DIN1;
        if (h1 && h2) begin
            pick = ~rr_last;
        end else if (h2) begin
            pick = SEL_DIN2;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fu_operand_join_merge_elastic_buffer.sv
// 2-entry elastic FIFO; a word written at cycle t is at the head at t+1.
// Ready depends on registered occupancy only, so downstream pop never reaches din_r_o.
import fu_operand_join_merge_pkg::*;

module fu_elastic_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = FU_IN_BUF_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  din_v_i,
    output logic                  din_r_o,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  push;
    logic                  pop;

    assign din_r_o = (count_q != FULL);
    assign push    = din_v_i & din_r_o;
    assign pop     = pop_i & (count_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage is datapath only; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (!push && pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fu_operand_join_merge.sv
// CGRA PE operand stage: buffers din_1/din_2 and joins, merges or passes them to FU control.
// One cycle from input accept to output token; inputs stall only on full buffers.
import fu_operand_join_merge_pkg::*;

module fu_operand_join_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = FU_IN_BUF_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] din_1_i,
    input  logic                  din_1_v_i,
    output logic                  din_1_r_o,
    input  logic [DATA_WIDTH-1:0] din_2_i,
    input  logic                  din_2_v_i,
    output logic                  din_2_r_o,
    output logic [DATA_WIDTH-1:0] op_a_o,
    output logic [DATA_WIDTH-1:0] op_b_o,
    output logic                  cin_o,
    output logic                  out_v_o,
    input  logic                  out_r_i
);

    fu_in_mode_t           mode;
    logic [DATA_WIDTH-1:0] head_1;
    logic [DATA_WIDTH-1:0] head_2;
    logic [1:0]            count_1;
    logic [1:0]            count_2;
    logic                  h1;
    logic                  h2;
    logic                  pop_1;
    logic                  pop_2;

    logic                  out_v;
    logic                  hs;
    logic                  win;
    logic                  cin;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    logic                  rr_last_q;
    logic                  lock_q;
    logic                  grant_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;

    assign mode = fu_in_mode_t'(mode_i);

    fu_elastic_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf_1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .din_i   (din_1_i),
        .din_v_i (din_1_v_i),
        .din_r_o (din_1_r_o),
        .pop_i   (pop_1),
        .head_o  (head_1),
        .count_o (count_1)
    );

    fu_elastic_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf_2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .din_i   (din_2_i),
        .din_v_i (din_2_v_i),
        .din_r_o (din_2_r_o),
        .pop_i   (pop_2),
        .head_o  (head_2),
        .count_o (count_2)
    );

    assign h1 = (count_1 != 2'd0);
    assign h2 = (count_2 != 2'd0);

    always_comb begin
        out_v = 1'b0;
        hs    = 1'b0;
        win   = SEL_DIN1;
        cin   = 1'b0;
        sel_a = head_1;
        sel_b = head_2;
        pop_1 = 1'b0;
        pop_2 = 1'b0;
        case (mode)
            FU_IN_JOIN: begin
                out_v = h1 & h2;
                hs    = out_v & out_r_i;
                pop_1 = hs;
                pop_2 = hs;
            end
            FU_IN_MERGE: begin
                // A stalled grant stays put; its head cannot leave before the handshake.
                win   = lock_q ? grant_q : rr_pick(h1, h2, rr_last_q);
                out_v = h1 | h2;
                hs    = out_v & out_r_i;
                cin   = out_v & win;
                sel_a = (win == SEL_DIN2) ? head_2 : head_1;
                sel_b = sel_a;
                pop_1 = hs & (win == SEL_DIN1);
                pop_2 = hs & (win == SEL_DIN2);
            end
            FU_IN_PASS1: begin
                out_v = h1;
                hs    = out_v & out_r_i;
                sel_b = head_1;
                pop_1 = hs;
            end
            FU_IN_PASS2: begin
                out_v = h2;
                hs    = out_v & out_r_i;
                sel_a = head_2;
                pop_2 = hs;
            end
            default: begin
                out_v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last_q <= SEL_DIN2;
            lock_q    <= 1'b0;
            grant_q   <= SEL_DIN1;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            lock_q <= (mode == FU_IN_MERGE) & out_v & ~out_r_i;
            if (out_v) begin
                grant_q <= win;
                op_a_q  <= sel_a;
                op_b_q  <= sel_b;
            end
            if ((mode == FU_IN_MERGE) && hs) begin
                rr_last_q <= win;
            end
        end
    end

    // Idle outputs keep the last presented operands so the datapath does not toggle.
    assign op_a_o  = out_v ? sel_a : op_a_q;
    assign op_b_o  = out_v ? sel_b : op_b_q;
    assign cin_o   = cin;
    assign out_v_o = out_v;

endmodule
